fsm_amplitude_multi: RTL and testbench

- Multi-channel amplitude extractor for the stabilizer-state emulator.
- For each of NUM_CH Pauli rows, it scans the NUM_QUBIT literals as they rotate past position 0. It accumulates the i-factors from Y literals and from the phase sign, then produces a complex amplitude from the set {+1, -1, +i, -i, 0}.
- Adds three things the single/dual-row extractor lacks: a per-channel enable mask, a registered cross-channel amplitude sum, and a busy/ignore handshake.
- Sits between the stabilizer row registers (it drives their rotate-left loads) and the global-phase / amplitude-accumulation logic.

---
 rtl/fsm_amplitude_multi.sv | 161 ++++++++++++++++
 tb/tb_fsm_amplitude_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_amplitude_multi.sv
// Multi-channel amplitude extractor for the stabilizer-state emulator.
// Each enabled channel scans NUM_QUBIT literals as the row rotates past
// position 0. It counts Y literals plus the phase sign as a power of i,
// then reports the amplitude i^k per channel together with a cross-channel sum.
module fsm_amplitude_multi #(
   parameter int NUM_QUBIT = 4,
   parameter int NUM_CH    = 2,
   parameter int AMP_WIDTH = 32
) (
   input  logic                        clk,
   input  logic                        rst_new,
   input  logic                        determine_amplitude,
   input  logic [NUM_CH-1:0]           ch_en,
   input  logic [1:0]                  lit0 [0:NUM_CH-1],
   input  logic [NUM_CH-1:0]           phase,
   input  logic [NUM_CH-1:0]           match_index,
   output logic                        busy,
   output logic                        done_amplitude,
   output logic [NUM_CH-1:0]           ld_rotate_left,
   output logic [1:0]                  amp_exp [0:NUM_CH-1],
   output logic signed [AMP_WIDTH-1:0] amp_r [0:NUM_CH-1],
   output logic signed [AMP_WIDTH-1:0] amp_i [0:NUM_CH-1],
   output logic signed [AMP_WIDTH-1:0] amp_sum_r,
   output logic signed [AMP_WIDTH-1:0] amp_sum_i
);

   // The counter only has to hold NUM_QUBIT-1; keep it at least one bit wide.
   localparam int CW = (NUM_QUBIT > 1) ? $clog2(NUM_QUBIT) : 1;

   localparam logic signed [AMP_WIDTH-1:0] AMP_ONE = AMP_WIDTH'(1);
   localparam logic signed [AMP_WIDTH-1:0] AMP_NEG = '1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SCAN  = 2'd1,
      S_FINAL = 2'd2
   } state_t;

   state_t                       r_state;
   logic [CW-1:0]                r_cnt;
   logic                         r_busy;
   logic                         r_done;
   logic [NUM_CH-1:0]            r_ch_en;
   logic [1:0]                   r_k       [0:NUM_CH-1];
   logic [1:0]                   r_amp_exp [0:NUM_CH-1];
   logic signed [AMP_WIDTH-1:0]  r_amp_r   [0:NUM_CH-1];
   logic signed [AMP_WIDTH-1:0]  r_amp_i   [0:NUM_CH-1];
   logic signed [AMP_WIDTH-1:0]  r_sum_r;
   logic signed [AMP_WIDTH-1:0]  r_sum_i;

   logic [NUM_CH-1:0]            w_is_y;
   logic [NUM_CH-1:0]            w_ch_en_eff;
   logic                         w_rot_phase;
   logic [1:0]                   w_exp     [0:NUM_CH-1];
   logic signed [AMP_WIDTH-1:0]  w_amp_r   [0:NUM_CH-1];
   logic signed [AMP_WIDTH-1:0]  w_amp_i   [0:NUM_CH-1];
   logic signed [AMP_WIDTH-1:0]  w_sum_r;
   logic signed [AMP_WIDTH-1:0]  w_sum_i;

   // Per-channel Y detection and output wiring.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_is_y[gi]  = (lit0[gi] == 2'd3);
      assign amp_exp[gi] = r_amp_exp[gi];
      assign amp_r[gi]   = r_amp_r[gi];
      assign amp_i[gi]   = r_amp_i[gi];
   end

   assign busy           = r_busy;
   assign done_amplitude = r_done;
   assign amp_sum_r      = r_sum_r;
   assign amp_sum_i      = r_sum_i;

   // Rotate pulses follow the live mask on the start cycle and the latched mask
   // afterwards, so a row is rotated exactly NUM_QUBIT times and ends aligned.
   assign w_ch_en_eff    = (r_state == S_IDLE) ? ch_en : r_ch_en;
   assign w_rot_phase    = ((r_state == S_IDLE) && determine_amplitude) || (r_state == S_SCAN);
   assign ld_rotate_left = rst_new ? (w_ch_en_eff & {NUM_CH{w_rot_phase}}) : '0;

   // Map each exponent to its complex amplitude and form the cross-channel sum.
   always_comb begin
      w_sum_r = '0;
      w_sum_i = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_exp[c]   = 2'd0;
         w_amp_r[c] = '0;
         w_amp_i[c] = '0;
         if (r_ch_en[c] && match_index[c]) begin
            w_exp[c] = r_k[c];
            case (r_k[c])
               2'd0:    w_amp_r[c] = AMP_ONE;
               2'd1:    w_amp_i[c] = AMP_ONE;
               2'd2:    w_amp_r[c] = AMP_NEG;
               default: w_amp_i[c] = AMP_NEG;
            endcase
         end
         w_sum_r = w_sum_r + w_amp_r[c];
         w_sum_i = w_sum_i + w_amp_i[c];
      end
   end

   // Control FSM with registered results; the reset state encodes amplitude 1.
   always_ff @(posedge clk) begin
      if (!rst_new) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_ch_en <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_k[c]       <= 2'd0;
            r_amp_exp[c] <= 2'd0;
            r_amp_r[c]   <= (c == 0) ? AMP_ONE : '0;
            r_amp_i[c]   <= '0;
         end
         r_sum_r <= AMP_ONE;
         r_sum_i <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (determine_amplitude) begin
                  r_ch_en <= ch_en;
                  for (int c = 0; c < NUM_CH; c++) begin
                     // 2*phase + Y never carries out of two bits.
                     r_k[c] <= {phase[c], w_is_y[c]};
                  end
                  r_cnt   <= CW'(NUM_QUBIT - 1);
                  r_busy  <= 1'b1;
                  r_state <= (NUM_QUBIT == 1) ? S_FINAL : S_SCAN;
               end
            end
            S_SCAN: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  r_k[c] <= r_k[c] + {1'b0, w_is_y[c]};
               end
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= S_FINAL;
               end
            end
            S_FINAL: begin
               for (int c = 0; c < NUM_CH; c++) begin
                  r_amp_exp[c] <= w_exp[c];
                  r_amp_r[c]   <= w_amp_r[c];
                  r_amp_i[c]   <= w_amp_i[c];
               end
               r_sum_r <= w_sum_r;
               r_sum_i <= w_sum_i;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_amplitude_multi.sv
// Bench for fsm_amplitude_multi: a row emulator feeds lit0 from rotation pulses,
// and a counting model computes the expected amplitudes and sums.
module tb_fsm_amplitude_multi;

   localparam int NQ  = 4;
   localparam int NCH = 2;
   localparam int AW  = 32;

   logic                 clk = 1'b0;
   logic                 rst_new;
   logic                 det;
   logic [NCH-1:0]       ch_en;
   logic [NCH-1:0]       phase;
   logic [NCH-1:0]       match_index;
   logic [1:0]           lit0 [0:NCH-1];
   logic                 busy;
   logic                 done_amplitude;
   logic [NCH-1:0]       ld_rotate_left;
   logic [1:0]           amp_exp [0:NCH-1];
   logic signed [AW-1:0] amp_r [0:NCH-1];
   logic signed [AW-1:0] amp_i [0:NCH-1];
   logic signed [AW-1:0] amp_sum_r;
   logic signed [AW-1:0] amp_sum_i;

   int vectors     = 0;
   int miscompares = 0;

   // Row contents and the emulated rotation position of each row.
   logic [1:0] row_lit [NCH][NQ];
   int         pos       [NCH] = '{default: 0};
   int         rot_total [NCH] = '{default: 0};

   // Transaction parameters as seen by the model.
   logic [NCH-1:0] txn_en;
   logic [NCH-1:0] txn_ph;
   logic [NCH-1:0] txn_mt;

   always #5 clk = ~clk;

   fsm_amplitude_multi #(
      .NUM_QUBIT (NQ),
      .NUM_CH    (NCH),
      .AMP_WIDTH (AW)
   ) dut (
      .clk                 (clk),
      .rst_new             (rst_new),
      .determine_amplitude (det),
      .ch_en               (ch_en),
      .lit0                (lit0),
      .phase               (phase),
      .match_index         (match_index),
      .busy                (busy),
      .done_amplitude      (done_amplitude),
      .ld_rotate_left      (ld_rotate_left),
      .amp_exp             (amp_exp),
      .amp_r               (amp_r),
      .amp_i               (amp_i),
      .amp_sum_r           (amp_sum_r),
      .amp_sum_i           (amp_sum_i)
   );

   // Row emulator: each rotate pulse moves the next literal to position 0.
   always @(posedge clk) begin
      for (int c = 0; c < NCH; c++) begin
         if (ld_rotate_left[c]) begin
            pos[c]       <= (pos[c] + 1) % NQ;
            rot_total[c] <= rot_total[c] + 1;
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_lit
      assign lit0[g] = row_lit[g][pos[g]];
   end

   initial begin
      #500000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model: k = 2*phase + (number of Y in the row), mod 4. The result does not
   // depend on which literal starts at position 0.
   function automatic int model_k(int c);
      int ny = 0;
      for (int j = 0; j < NQ; j++) if (row_lit[c][j] == 2'd3) ny++;
      return (2 * int'(txn_ph[c]) + ny) % 4;
   endfunction

   function automatic bit model_live(int c);
      return txn_en[c] && txn_mt[c];
   endfunction

   function automatic int model_r(int c);
      int k;
      if (!model_live(c)) return 0;
      k = model_k(c);
      return (k % 2 == 0) ? 1 - k : 0;
   endfunction

   function automatic int model_i(int c);
      int k;
      if (!model_live(c)) return 0;
      k = model_k(c);
      return (k % 2 == 1) ? 2 - k : 0;
   endfunction

   function automatic int model_exp(int c);
      return model_live(c) ? model_k(c) : 0;
   endfunction

   task automatic check_results(input string pfx);
      int sr = 0;
      int si = 0;
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("%s amp_r[%0d]", pfx, c), amp_r[c], model_r(c));
         chk($sformatf("%s amp_i[%0d]", pfx, c), amp_i[c], model_i(c));
         chk($sformatf("%s amp_exp[%0d]", pfx, c), amp_exp[c], model_exp(c));
         sr += model_r(c);
         si += model_i(c);
      end
      chk($sformatf("%s amp_sum_r", pfx), amp_sum_r, sr);
      chk($sformatf("%s amp_sum_i", pfx), amp_sum_i, si);
   endtask

   task automatic check_reset_vals(input string pfx);
      chk({pfx, " busy"}, busy, 0);
      chk({pfx, " done"}, done_amplitude, 0);
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("%s amp_r[%0d]", pfx, c), amp_r[c], (c == 0) ? 1 : 0);
         chk($sformatf("%s amp_i[%0d]", pfx, c), amp_i[c], 0);
         chk($sformatf("%s amp_exp[%0d]", pfx, c), amp_exp[c], 0);
      end
      chk({pfx, " amp_sum_r"}, amp_sum_r, 1);
      chk({pfx, " amp_sum_i"}, amp_sum_i, 0);
   endtask

   // One start pulse, optional ignored start while busy, then full result check.
   task automatic run_txn(input string pfx, input logic [NCH-1:0] en, input logic [NCH-1:0] ph,
                          input logic [NCH-1:0] mt, input bit inject);
      int lat;
      int rot0 [NCH];
      @(negedge clk);
      for (int c = 0; c < NCH; c++) rot0[c] = rot_total[c];
      txn_en = en; txn_ph = ph; txn_mt = mt;
      ch_en = en; phase = ph; match_index = mt; det = 1'b1;
      #1;
      chk({pfx, " ld_at_start"}, ld_rotate_left, en);
      @(posedge clk);
      @(negedge clk);
      det   = inject;
      ch_en = NCH'($urandom);
      phase = NCH'($urandom);
      chk({pfx, " busy_after_start"}, busy, 1);
      lat = 0;
      while (lat < 3 * NQ + 10) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         det = 1'b0;
         if (done_amplitude) break;
         chk({pfx, " busy_during_scan"}, busy, 1);
      end
      chk({pfx, " latency"}, lat, NQ);
      chk({pfx, " busy_at_done"}, busy, 0);
      check_results(pfx);
      for (int c = 0; c < NCH; c++)
         chk($sformatf("%s rotations[%0d]", pfx, c), rot_total[c] - rot0[c], en[c] ? NQ : 0);
      @(negedge clk);
      chk({pfx, " done_single_pulse"}, done_amplitude, 0);
   endtask

   task automatic set_rows(input logic [2*NQ-1:0] r0, input logic [2*NQ-1:0] r1);
      for (int j = 0; j < NQ; j++) begin
         row_lit[0][j] = r0[2*(NQ-1-j) +: 2];
         if (NCH > 1) row_lit[1][j] = r1[2*(NQ-1-j) +: 2];
      end
   endtask

   initial begin
      rst_new = 1'b0; det = 1'b0; ch_en = '0; phase = '0; match_index = '0;
      for (int c = 0; c < NCH; c++) for (int j = 0; j < NQ; j++) row_lit[c][j] = 2'd0;

      // Reset, including a start request that reset must override.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      det = 1'b1; ch_en = '1;
      #1;
      chk("reset ld_rotate_left", ld_rotate_left, 0);
      det = 1'b0; ch_en = '0;
      @(negedge clk);
      rst_new = 1'b1;
      @(negedge clk);
      check_reset_vals("idle");
      chk("idle ld_rotate_left", ld_rotate_left, 0);

      // Ch0 Y,X,Y,Z phase 0; ch1 Y,I,I,I phase 1 (I=0, X=1, Z=2, Y=3).
      set_rows(8'b11_01_11_10, 8'b11_00_00_00);
      run_txn("basic", 2'b11, 2'b10, 2'b11, 1'b0);
      chk("basic const amp_r0", amp_r[0], -1);
      chk("basic const amp_i1", amp_i[1], -1);
      chk("basic const sum_r", amp_sum_r, -1);
      chk("basic const sum_i", amp_sum_i, -1);

      run_txn("nomatch1", 2'b11, 2'b10, 2'b01, 1'b0);
      chk("nomatch1 const sum_r", amp_sum_r, -1);
      chk("nomatch1 const sum_i", amp_sum_i, 0);
      run_txn("en01", 2'b01, 2'b10, 2'b11, 1'b0);
      chk("en01 const amp_i1", amp_i[1], 0);

      // Start held high for 12 edges: accepted at 0, NQ+1, 2(NQ+1), ...
      @(negedge clk);
      txn_en = 2'b11; txn_ph = 2'b10; txn_mt = 2'b11;
      ch_en = 2'b11; phase = 2'b10; match_index = 2'b11; det = 1'b1;
      for (int t = 0; t < 3 * (NQ + 1) + NQ + 2; t++) begin
         bit exp_done;
         int a;
         @(posedge clk);
         @(negedge clk);
         if (t == 11) det = 1'b0;
         a = t - NQ;
         exp_done = (a >= 0) && (a % (NQ + 1) == 0) && (a < 12);
         chk($sformatf("held done t=%0d", t), done_amplitude, exp_done);
         if (done_amplitude) check_results("held");
      end

      // Reset two cycles into a scan: no done, reset values, then recovery.
      @(negedge clk);
      ch_en = 2'b11; phase = 2'b00; match_index = 2'b11; det = 1'b1;
      @(posedge clk);
      @(negedge clk);
      det = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_new = 1'b0;
      @(negedge clk);
      check_reset_vals("midreset");
      chk("midreset ld_rotate_left", ld_rotate_left, 0);
      rst_new = 1'b1;
      for (int t = 0; t < NQ + 3; t++) begin
         @(negedge clk);
         chk("midreset no_done", done_amplitude, 0);
      end
      run_txn("after_reset", 2'b11, 2'b01, 2'b11, 1'b0);

      // All Y with phase 1: exponent wraps mod 4.
      set_rows(8'b11_11_11_11, 8'b11_11_11_11);
      run_txn("wrap", 2'b11, 2'b11, 2'b11, 1'b0);
      chk("wrap const sum_r", amp_sum_r, -2);

      // Randomized transactions.
      for (int n = 0; n < 40; n++) begin
         for (int c = 0; c < NCH; c++)
            for (int j = 0; j < NQ; j++) row_lit[c][j] = 2'($urandom_range(0, 3));
         run_txn($sformatf("rand%0d", n), NCH'($urandom), NCH'($urandom), NCH'($urandom),
                 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
